// File: rtl/myip_pkg.sv
// Shared constants and state encoding for the matrix-vector coprocessor.
package myip_pkg;

  localparam int unsigned DEF_A_DEPTH_BITS   = 9;
  localparam int unsigned DEF_B_DEPTH_BITS   = 3;
  localparam int unsigned DEF_RES_DEPTH_BITS = 6;
  localparam int unsigned DEF_WIDTH          = 8;
  localparam int unsigned AXIS_W             = 32;

  localparam int unsigned IN_WORDS  = (1 << DEF_A_DEPTH_BITS) + (1 << DEF_B_DEPTH_BITS);
  localparam int unsigned OUT_WORDS = 1 << DEF_RES_DEPTH_BITS;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE          = 2'd0;
  localparam state_t ST_READ_INPUTS   = 2'd1;
  localparam state_t ST_COMPUTE       = 2'd2;
  localparam state_t ST_WRITE_OUTPUTS = 2'd3;

endpackage

// File: rtl/memory_ram.sv
// Single-port synchronous RAM, read-before-write, one-cycle read latency.
module memory_ram #(
  parameter int unsigned depth_bits = 8,
  parameter int unsigned width      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [depth_bits-1:0] addr,
  input  logic [width-1:0]      din,
  output logic [width-1:0]      dout
);

  logic [width-1:0] mem [2**depth_bits];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/myip.sv
// AXI4-Stream coprocessor: loads A (64x8) and B (8x1), streams out (A*B)/256.
module myip
  import myip_pkg::*;
#(
  parameter int unsigned A_DEPTH_BITS   = DEF_A_DEPTH_BITS,
  parameter int unsigned B_DEPTH_BITS   = DEF_B_DEPTH_BITS,
  parameter int unsigned RES_DEPTH_BITS = DEF_RES_DEPTH_BITS,
  parameter int unsigned WIDTH          = DEF_WIDTH
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [AXIS_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY,
  output logic [AXIS_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY
);

  localparam int unsigned CNT_W   = A_DEPTH_BITS + 1;
  localparam int unsigned COL_W   = B_DEPTH_BITS + 1;
  localparam int unsigned FETCH_W = RES_DEPTH_BITS + 1;
  localparam int unsigned ACC_W   = 2 * WIDTH + B_DEPTH_BITS + 1;
  localparam int unsigned A_WORDS = 1 << A_DEPTH_BITS;
  localparam int unsigned ROW_LEN = 1 << B_DEPTH_BITS;
  localparam int unsigned IN_LAST = A_WORDS + ROW_LEN - 1;
  localparam int unsigned N_OUT   = 1 << RES_DEPTH_BITS;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
  logic [RES_DEPTH_BITS-1:0] row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 s_tready_q, s_tready_d;
  logic [FETCH_W-1:0]   fetch_q, fetch_d;
  logic                 pend_q, pend_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [WIDTH-1:0]     m_tdata_q, m_tdata_d;

  logic                      a_we_c, b_we_c, res_we_c;
  logic [A_DEPTH_BITS-1:0]   a_addr_c;
  logic [B_DEPTH_BITS-1:0]   b_addr_c;
  logic [RES_DEPTH_BITS-1:0] res_addr_c;
  logic [WIDTH-1:0]          a_dout, b_dout, res_dout, res_din_c;
  logic [2*WIDTH-1:0]        prod_c;
  logic [FETCH_W-1:0]        fetch_prev_c;
  logic                      s_beat_c, load_c, issue_c;
  logic                      unused_c;

  assign unused_c     = ^{S_AXIS_TLAST, S_AXIS_TDATA[AXIS_W-1:WIDTH]};
  assign s_beat_c     = S_AXIS_TVALID & s_tready_q;
  assign prod_c       = a_dout * b_dout;
  assign fetch_prev_c = fetch_q - FETCH_W'(1);

  // Output prefetch: RAM dout acts as a one-deep stage; its address is held while stalled.
  assign load_c  = (state_q == ST_WRITE_OUTPUTS) && pend_q && (!m_tvalid_q || M_AXIS_TREADY);
  assign issue_c = (state_q == ST_WRITE_OUTPUTS) && (fetch_q < FETCH_W'(N_OUT)) &&
                   (!pend_q || load_c);

  memory_ram #(.depth_bits(A_DEPTH_BITS), .width(WIDTH)) u_ram_a (
    .clk(ACLK), .we(a_we_c), .addr(a_addr_c), .din(S_AXIS_TDATA[WIDTH-1:0]), .dout(a_dout)
  );

  memory_ram #(.depth_bits(B_DEPTH_BITS), .width(WIDTH)) u_ram_b (
    .clk(ACLK), .we(b_we_c), .addr(b_addr_c), .din(S_AXIS_TDATA[WIDTH-1:0]), .dout(b_dout)
  );

  memory_ram #(.depth_bits(RES_DEPTH_BITS), .width(WIDTH)) u_ram_res (
    .clk(ACLK), .we(res_we_c), .addr(res_addr_c), .din(res_din_c), .dout(res_dout)
  );

  // Next-state, counters, MAC and output stage.
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    s_tready_d = s_tready_q;
    fetch_d    = fetch_q;
    pend_d     = pend_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    a_we_c     = 1'b0;
    b_we_c     = 1'b0;
    res_we_c   = 1'b0;
    a_addr_c   = in_cnt_q[A_DEPTH_BITS-1:0];
    b_addr_c   = in_cnt_q[B_DEPTH_BITS-1:0];
    res_addr_c = row_q;
    res_din_c  = acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      ST_IDLE: begin
        in_cnt_d = '0;
        row_d    = '0;
        col_d    = '0;
        fetch_d  = '0;
        pend_d   = 1'b0;
        if (S_AXIS_TVALID) begin
          state_d    = ST_READ_INPUTS;
          s_tready_d = 1'b1;
        end
      end

      ST_READ_INPUTS: begin
        if (s_beat_c) begin
          if (in_cnt_q < CNT_W'(A_WORDS)) a_we_c = 1'b1;
          else                            b_we_c = 1'b1;
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == CNT_W'(IN_LAST)) begin
            s_tready_d = 1'b0;
            state_d    = ST_COMPUTE;
          end
        end
      end

      // Per row: col 0..7 issue reads, col 1..8 accumulate, col 9 stores the result.
      ST_COMPUTE: begin
        a_addr_c = {row_q, col_q[B_DEPTH_BITS-1:0]};
        b_addr_c = col_q[B_DEPTH_BITS-1:0];
        col_d    = col_q + COL_W'(1);
        if (col_q == '0) begin
          acc_d = '0;
        end else if (col_q <= COL_W'(ROW_LEN)) begin
          acc_d = acc_q + ACC_W'(prod_c);
        end
        if (col_q == COL_W'(ROW_LEN + 1)) begin
          res_we_c = 1'b1;
          col_d    = '0;
          row_d    = row_q + RES_DEPTH_BITS'(1);
          if (row_q == '1) begin
            state_d = ST_WRITE_OUTPUTS;
            fetch_d = '0;
            pend_d  = 1'b0;
          end
        end
      end

      ST_WRITE_OUTPUTS: begin
        res_addr_c = issue_c ? fetch_q[RES_DEPTH_BITS-1:0] : fetch_prev_c[RES_DEPTH_BITS-1:0];
        if (m_tvalid_q && M_AXIS_TREADY) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          if (m_tlast_q) state_d = ST_IDLE;
        end
        if (load_c) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = res_dout;
          m_tlast_d  = (fetch_prev_c == FETCH_W'(N_OUT - 1));
        end
        if (issue_c) fetch_d = fetch_q + FETCH_W'(1);
        pend_d = issue_c | (pend_q & ~load_c);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      in_cnt_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      s_tready_q <= 1'b0;
      fetch_q    <= '0;
      pend_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      s_tready_q <= s_tready_d;
      fetch_q    <= fetch_d;
      pend_q     <= pend_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

  assign S_AXIS_TREADY = s_tready_q;
  assign M_AXIS_TVALID = m_tvalid_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TDATA  = AXIS_W'(m_tdata_q);

endmodule

// File: tb/tb_myip.sv
// Directed bench for myip: golden results queued per vector, checked beat by beat.
module tb_myip;
  import myip_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tready;

  int checks = 0;
  int errors = 0;

  logic [7:0] a_mem [512];
  logic [7:0] b_mem [8];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  myip dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TREADY(m_tready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 512; i++) a_mem[i] = av;
    for (int j = 0; j < 8; j++) b_mem[j] = bv;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) a_mem[i] = 8'($urandom_range(0, 255));
    for (int j = 0; j < 8; j++) b_mem[j] = 8'($urandom_range(0, 255));
  endtask

  // Golden model: 20-bit unsigned dot product per row, keep bits [15:8].
  task automatic push_expected();
    logic [19:0] acc;
    for (int i = 0; i < 64; i++) begin
      acc = '0;
      for (int j = 0; j < 8; j++) acc = acc + 20'(a_mem[i*8+j]) * 20'(b_mem[j]);
      exp_q.push_back(acc[15:8]);
    end
  endtask

  task automatic send_vector(input int gap_at);
    int         timeouts;
    int         w;
    logic       accepted;
    logic [7:0] word;
    timeouts = 0;
    push_expected();
    for (int k = 0; k < 520; k++) begin
      if (k == gap_at) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      word     = (k < 512) ? a_mem[k] : b_mem[k-512];
      s_tdata  = {24'($urandom()), word};
      s_tvalid = 1'b1;
      accepted = 1'b0;
      w        = 0;
      while (!accepted && w < 2000) begin
        @(negedge clk);
        accepted = s_tready;
        @(posedge clk); #1;
        w++;
      end
      if (!accepted) timeouts++;
    end
    s_tvalid = 1'b0;
    chk("in_timeouts", 32'(timeouts), 32'd0);
    @(negedge clk);
    chk("tready_after_last", 32'(s_tready), 32'd0);
  endtask

  task automatic recv(input int stall_at);
    int         beat;
    int         w;
    logic [7:0] e;
    beat     = 0;
    w        = 0;
    m_tready = 1'b1;
    while (beat < 64 && w < 3000) begin
      @(negedge clk);
      w++;
      if (m_tvalid) begin
        if (beat == stall_at) begin
          m_tready = 1'b0;
          @(negedge clk);
          w++;
          chk("stall_tvalid", 32'(m_tvalid), 32'd1);
          chk("stall_tdata", m_tdata, (exp_q.size() > 0) ? {24'h0, exp_q[0]} : 32'hxxxx_xxxx);
          m_tready = 1'b1;
        end
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("res", m_tdata, {24'h0, e});
        chk("tlast", 32'(m_tlast), 32'(beat == 63));
        beat++;
      end
    end
    chk("out_beats", 32'(beat), 32'd64);
    @(negedge clk);
    chk("tvalid_idle", 32'(m_tvalid), 32'd0);
    chk("tlast_idle", 32'(m_tlast), 32'd0);
    chk("s_tready_idle", 32'(s_tready), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small products truncate to zero
    fill_const(8'd1, 8'd2);
    send_vector(-1);
    recv(-1);

    // acc = 2048 -> 0x08
    fill_const(8'd16, 8'd16);
    send_vector(-1);
    recv(-1);

    // Maximum operands -> 0xF0
    fill_const(8'd255, 8'd255);
    send_vector(-1);
    recv(-1);

    // Input gap after two beats
    fill_rand();
    send_vector(2);
    recv(-1);

    // Output stall mid-stream
    fill_rand();
    send_vector(-1);
    recv(30);

    // Back-to-back vectors with the same glitches
    fill_rand();
    send_vector(2);
    recv(30);
    fill_rand();
    send_vector(2);
    recv(30);

    // Stall on the final beat
    fill_rand();
    send_vector(511);
    recv(63);

    // Reset during COMPUTE aborts; a fresh vector then runs cleanly
    fill_rand();
    send_vector(-1);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_s_tready", 32'(s_tready), 32'd0);
    chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_m_tlast", 32'(m_tlast), 32'd0);
    chk("arst_m_tdata", m_tdata, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_rand();
    send_vector(2);
    recv(10);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
